// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, a two-entry
// (main + skid) buffer, synchronous flush and a saturating stall counter.
// Every output is taken straight from a register or decoded from the state
// register, so valid_i never reaches valid_o and ready_i never reaches
// ready_o within the same cycle.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // Reject widths that would leave a zero-width bus or a useless counter.
  if (CTRL_W < 1) begin : g_bad_ctrl_w
    $error("pipe_stage_reg: CTRL_W must be >= 1");
  end
  if (DATA_W < 1) begin : g_bad_data_w
    $error("pipe_stage_reg: DATA_W must be >= 1");
  end
  if (CNT_W < 2) begin : g_bad_cnt_w
    $error("pipe_stage_reg: CNT_W must be >= 2");
  end

  // EMPTY: nothing held. HALF: main holds a beat. FULL: main and skid hold beats.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              in_fire;
  logic              out_fire;

  assign valid_o     = (state_q != EMPTY);
  assign ready_o     = (state_q != FULL);
  assign ctrl_o      = main_ctrl_q;
  assign data_o      = main_data_q;
  assign stall_cnt_o = stall_cnt_q;

  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  // Next-state and next-storage logic; main_ctrl is zeroed whenever the main
  // entry becomes empty so bubbles never carry live control bits downstream.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    stall_cnt_d = stall_cnt_q;

    if (valid_o && !ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    if (flush_i) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = HALF;
            main_ctrl_d = ctrl_i;
            main_data_d = data_i;
          end
        end
        HALF: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = ctrl_i;
            main_data_d = data_i;
          end else if (in_fire) begin
            state_d     = FULL;
            skid_ctrl_d = ctrl_i;
            skid_data_d = data_i;
          end else if (out_fire) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d     = HALF;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
            skid_data_d = '0;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_ctrl_d = '0;
        end
      endcase
    end
  end

  // State and storage registers; reset outranks flush and every handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg. A scoreboard queue holds accepted beats
// in order and an occupancy model predicts valid_o/ready_o; a second instance
// with a 2-bit counter shares all inputs to exercise counter saturation.
module tb_pipe_stage_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_i;
  logic [7:0]  ctrl_i;
  logic [31:0] data_i;

  logic        ready_o, valid_o;
  logic [7:0]  ctrl_o;
  logic [31:0] data_o;
  logic [15:0] stall_cnt_o;

  logic        sat_ready_o, sat_valid_o;
  logic [7:0]  sat_ctrl_o;
  logic [31:0] sat_data_o;
  logic [1:0]  sat_stall_cnt_o;

  int          vectors = 0;
  int          miscompares = 0;

  logic [39:0] sb_q[$];
  bit          model_known = 1'b0;
  bit          just_reset = 1'b0;
  int          stall16 = 0;
  int          stall2 = 0;

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .CNT_W(16)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .ctrl_i(ctrl_i), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .ctrl_o(ctrl_o), .data_o(data_o),
    .stall_cnt_o(stall_cnt_o)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .CNT_W(2)) u_sat (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(sat_ready_o), .ctrl_i(ctrl_i), .data_i(data_i),
    .valid_o(sat_valid_o), .ready_i(ready_i), .ctrl_o(sat_ctrl_o), .data_o(sat_data_o),
    .stall_cnt_o(sat_stall_cnt_o)
  );

  task automatic check_val(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] c, input logic [31:0] d,
                               input logic r, input logic f, input logic rs);
    valid_i = v;
    ctrl_i  = c;
    data_i  = d;
    ready_i = r;
    flush_i = f;
    rst_i   = rs;
  endtask

  // Compare outputs mid-cycle against the model, then advance the model by
  // the edge that is about to happen and step past that edge.
  task automatic checkOutput();
    bit vexp;
    bit rexp;
    @(negedge clk_i);
    if (model_known) begin
      vexp = (sb_q.size() != 0);
      rexp = (sb_q.size() != 2);
      check_val("valid_o", {31'd0, valid_o}, {31'd0, vexp});
      check_val("ready_o", {31'd0, ready_o}, {31'd0, rexp});
      check_val("stall_cnt_o", {16'd0, stall_cnt_o}, stall16);
      check_val("sat_stall_cnt_o", {30'd0, sat_stall_cnt_o}, stall2);
      check_val("sat_valid_o", {31'd0, sat_valid_o}, {31'd0, vexp});
      check_val("sat_ready_o", {31'd0, sat_ready_o}, {31'd0, rexp});
      check_val("data_o_known", {31'd0, $isunknown(data_o)}, 32'd0);
      if (vexp) begin
        check_val("data_o", data_o, sb_q[0][31:0]);
        check_val("ctrl_o", {24'd0, ctrl_o}, {24'd0, sb_q[0][39:32]});
        check_val("sat_data_o", sat_data_o, sb_q[0][31:0]);
      end else begin
        check_val("ctrl_o_bubble", {24'd0, ctrl_o}, 32'd0);
        check_val("sat_ctrl_o_bubble", {24'd0, sat_ctrl_o}, 32'd0);
      end
      if (just_reset) begin
        check_val("data_o_reset", data_o, 32'd0);
      end
    end
    if (rst_i) begin
      sb_q.delete();
      stall16     = 0;
      stall2      = 0;
      model_known = 1'b1;
      just_reset  = 1'b1;
    end else if (model_known) begin
      just_reset = 1'b0;
      vexp = (sb_q.size() != 0);
      rexp = (sb_q.size() != 2);
      if (vexp && !ready_i) begin
        if (stall16 < 65535) stall16++;
        if (stall2 < 3) stall2++;
      end
      if (flush_i) begin
        sb_q.delete();
      end else begin
        if (vexp && ready_i) void'(sb_q.pop_front());
        if (valid_i && rexp) sb_q.push_back({ctrl_i, data_i});
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic step(input logic v, input logic [7:0] c, input logic [31:0] d,
                      input logic r, input logic f, input logic rs);
    applyStimulus(v, c, d, r, f, rs);
    checkOutput();
  endtask

  // Directed sequence: reset, streaming, backpressure, flush, bubbles,
  // counter saturation and reset during a stall.
  initial begin
    $display("[TB] start");
    step(1'b0, 8'h00, 32'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 32'd0, 1'b1, 1'b0, 1'b1);

    // Back-to-back stream at full throughput.
    for (int i = 1; i <= 4; i++) step(1'b1, 8'hA5, i, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'hA5, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'hA5, 32'd0, 1'b1, 1'b0, 1'b0);

    // Backpressure fills main and skid, then drains in order.
    step(1'b1, 8'hA5, 32'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 32'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 32'd3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 32'd3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 32'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 32'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'hA5, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'hA5, 32'd0, 1'b1, 1'b0, 1'b0);

    // Flush while FULL, together with an incoming beat that must vanish.
    step(1'b1, 8'h3C, 32'd5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h3C, 32'd6, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h3C, 32'd7, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h3C, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h3C, 32'd0, 1'b1, 1'b0, 1'b0);

    // Bubbles between beats must not leak control bits.
    step(1'b1, 8'hFF, 32'd8, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'hFF, 32'hDEAD, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 32'd9, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'hFF, 32'd0, 1'b1, 1'b0, 1'b0);

    // Counter saturation after a fresh reset.
    step(1'b0, 8'h00, 32'd0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h11, 32'd10, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h11, 32'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h11, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h11, 32'd0, 1'b1, 1'b0, 1'b0);

    // Reset during a stall with both entries occupied.
    step(1'b1, 8'h22, 32'd11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 32'd12, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h22, 32'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 32'd13, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h44, 32'd9, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h44, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h44, 32'd0, 1'b1, 1'b0, 1'b0);

    if (sb_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: observed=%0d expected=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
